axi_addr_latch: RTL and testbench
=================================

// Module: axi_addr_latch
// PURPOSE
//  Captures one AXI3 address-channel request (AW or AR) and replays it as a sequence of
//  per-access peripheral addresses, one per O_VALID/O_READY handshake. O_LAST marks the
//  final access. Sits between the AXI slave address channel and the SRAM-side datapath of
//  a slave interface; one instance serves writes and one serves reads.
// PARAMETERS
//  masters  4   width of the one-hot MASTER tag carried with the request
//  width    22  address width in bits
//  p_size   3   peripheral data width = 2^p_size bytes
//  id_bits  2   transaction ID width
// PORTS
//  ACLK      in   1          clock; all state changes on the rising edge
//  ARESETn   in   1          reset
//  MASTER    in   masters    requesting master tag
//  ID        in   id_bits    transaction ID
//  ADDR      in   width      start byte address
//  LEN       in   4          beats-1 (1..16 beats)
//  SIZE      in   3          bytes per beat = 2^SIZE
//  BURST     in   2          0 FIXED, 1 INCR, 2 WRAP, 3 reserved (treated as INCR)
//  LOCK      in   2          accepted, ignored
//  CACHE     in   4          accepted, ignored
//  PROT      in   3          accepted, ignored
//  VALID     in   1          request valid
//  READY     out  1          request accepted when VALID&&READY
//  O_MASTER  out  masters    MASTER of the active request
//  O_ID      out  id_bits    ID of the active request
//  O_ADDR    out  width      byte address of the current peripheral access
//  O_LAST    out  1          current access is the last one of the burst
//  O_VALID   out  1          access valid
//  O_READY   in   1          consumer takes the access when O_VALID&&O_READY
// BEHAVIOUR
//  - Reset is ARESETn, synchronous, active-low; clock is ACLK. While reset is held:
//    O_VALID=0, O_LAST=0, O_ADDR=0, O_MASTER=0, O_ID=0, READY=0.
//  - FSM has two states.
//    IDLE: READY=1, O_VALID=0. VALID&&READY latches all fields and moves to BUSY.
//    BUSY: O_VALID=1, READY=0. Exception: READY=1 in the cycle the last access
//    handshakes, which allows back-to-back requests.
//  - Latency: request accepted at edge T drives O_VALID=1 with the first access from T+1.
//  - Access step: e = min(SIZE, p_size). Each beat splits into k = 2^(SIZE-e) accesses.
//    Total accesses = (LEN+1)*k.
//  - First O_ADDR = ADDR unmodified. Later accesses use aligned address A = O_ADDR & ~(2^e-1).
//  - On each O_VALID&&O_READY that is not last:
//    - INCR: next = A + 2^e. Arithmetic is modulo 2^width.
//    - FIXED: inside a beat, next = A + 2^e. After the last sub-access of a beat, return to
//      the beat's start address, aligned to 2^SIZE.
//    - WRAP: boundary B = (LEN+1)<<SIZE bytes. next = (A & ~(B-1)) | ((A+2^e) & (B-1)).
//  - O_LAST = 1 when the remaining-access counter is 1. O_MASTER and O_ID hold for the
//    whole burst.
//  - O_VALID stays high and O_ADDR stays stable until O_READY. No address advance
//    without a handshake.
//  - On the last handshake:
//    - With VALID=1 the new request is latched in the same edge. O_VALID stays 1 with the
//      new first address.
//    - Otherwise the FSM returns to IDLE and O_VALID and O_LAST go to 0.
//  - Reset mid-burst aborts immediately; all outputs return to their reset values.
// TESTING
//  1. INCR, ADDR=0x100, LEN=3, SIZE=3, p_size=3, O_READY=1 -> O_ADDR 0x100,0x108,0x110,0x118;
//     O_LAST only on 0x118; READY=1 again after.
//  2. SIZE=3, p_size=2, INCR, LEN=1, ADDR=0x40 -> 4 accesses 0x40,0x44,0x48,0x4C;
//     O_LAST on 0x4C.
//  3. WRAP, ADDR=0x38, LEN=3, SIZE=3, p_size=3 -> 0x38,0x20,0x28,0x30 (boundary 32 bytes).
//  4. FIXED, ADDR=0x80, LEN=2, SIZE=2, p_size=3 -> 0x80 three times; O_LAST on the third.
//  5. O_READY low for 3 cycles mid-burst -> O_ADDR/O_LAST/O_VALID held stable; with a 2nd
//     VALID pending at the last handshake, the next burst starts with no idle cycle.
//  6. ARESETn=0 during a burst -> next cycle O_VALID=0, O_ADDR=0, READY=0; after release
//     READY=1.

Source files
------------

// File: rtl/axi_addr_latch.sv
// -----------------------------------------------------------------------------
// axi_addr_latch
//
// Captures one AXI3 address-channel request (AW or AR). It then replays the
// request as a sequence of peripheral byte addresses, one per O_VALID/O_READY
// handshake. O_LAST flags the final access of the burst. A beat wider than
// the peripheral data path (SIZE > p_size) is split into 2^(SIZE-p_size)
// narrower accesses.
//
// Parameters
//   masters  width of the one-hot MASTER tag
//   width    address width in bits
//   p_size   peripheral data width = 2^p_size bytes
//   id_bits  transaction ID width
//
// Ports
//   ACLK, ARESETn         clock, synchronous active-low reset
//   MASTER, ID, ADDR,     request fields, latched on VALID && READY
//   LEN, SIZE, BURST
//   LOCK, CACHE, PROT     accepted for interface completeness, not used
//   VALID / READY         request handshake
//   O_MASTER, O_ID        tag of the active request, held for the burst
//   O_ADDR, O_LAST        current peripheral access
//   O_VALID / O_READY     access handshake
// -----------------------------------------------------------------------------
module axi_addr_latch #(
  parameter int masters = 4,
  parameter int width   = 22,
  parameter int p_size  = 3,
  parameter int id_bits = 2
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [masters-1:0] MASTER,
  input  logic [id_bits-1:0] ID,
  input  logic [width-1:0]   ADDR,
  input  logic [3:0]         LEN,
  input  logic [2:0]         SIZE,
  input  logic [1:0]         BURST,
  input  logic [1:0]         LOCK,
  input  logic [3:0]         CACHE,
  input  logic [2:0]         PROT,
  input  logic               VALID,
  output logic               READY,
  output logic [masters-1:0] O_MASTER,
  output logic [id_bits-1:0] O_ID,
  output logic [width-1:0]   O_ADDR,
  output logic               O_LAST,
  output logic               O_VALID,
  input  logic               O_READY
);

  // Up to 16 beats x 2^7 sub-accesses = 2048 accesses.
  localparam int CNT_W = 12;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t             state_q, state_d;
  logic [masters-1:0] master_q, master_d;
  logic [id_bits-1:0] id_q, id_d;
  logic [width-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;         // accesses remaining, incl. current
  logic [2:0]         e_q, e_d;             // log2 of access step in bytes
  logic [6:0]         kmask_q, kmask_d;     // sub-accesses per beat minus one
  logic [1:0]         burst_q, burst_d;
  logic [width-1:0]   fbase_q, fbase_d;     // FIXED: beat start, SIZE-aligned
  logic [width-1:0]   wmask_q, wmask_d;     // WRAP: boundary minus one

  // ---------------------------------------------------------------------------
  // Request decode: derived values that are latched together with the request
  // ---------------------------------------------------------------------------
  logic [2:0]       req_e;
  logic [2:0]       req_sub_log;
  logic [CNT_W-1:0] req_cnt;
  logic [6:0]       req_kmask;
  logic [width-1:0] req_fbase;
  logic [width-1:0] req_wmask;

  always_comb begin
    req_e       = (SIZE < 3'(p_size)) ? SIZE : 3'(p_size);
    req_sub_log = SIZE - req_e;
    req_cnt     = (CNT_W'(LEN) + CNT_W'(1)) << req_sub_log;
    req_kmask   = 7'((8'd1 << req_sub_log) - 8'd1);
    req_fbase   = ADDR & ~((width'(1) << SIZE) - width'(1));
    req_wmask   = ((width'(LEN) + width'(1)) << SIZE) - width'(1);
  end

  // ---------------------------------------------------------------------------
  // Address sequencing for the active burst
  // ---------------------------------------------------------------------------
  logic [width-1:0] step;
  logic [width-1:0] aligned;
  logic [width-1:0] incr;
  logic             beat_end;
  logic [width-1:0] next_addr;

  always_comb begin
    step    = width'(1) << e_q;
    aligned = addr_q & ~(step - width'(1));
    incr    = aligned + step;
    // Current access closes its beat when the accesses still to come after it
    // are a whole number of beats.
    beat_end = ((cnt_q - CNT_W'(1)) & CNT_W'(kmask_q)) == '0;
    unique case (burst_q)
      BURST_FIXED: next_addr = beat_end ? fbase_q : incr;
      BURST_WRAP:  next_addr = (aligned & ~wmask_q) | (incr & wmask_q);
      default:     next_addr = incr;     // INCR and reserved
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic busy;
  logic last;
  logic hs;
  logic accept;

  always_comb begin
    busy   = (state_q == S_BUSY);
    last   = busy && (cnt_q == CNT_W'(1));
    hs     = busy && O_READY;
    // READY is also open during the final access handshake so a queued
    // request is taken without a bubble.
    READY  = ARESETn && (!busy || (hs && last));
    accept = VALID && READY;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    id_d     = id_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    e_d      = e_q;
    kmask_d  = kmask_q;
    burst_d  = burst_q;
    fbase_d  = fbase_q;
    wmask_d  = wmask_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (hs && last) begin
          state_d = accept ? S_BUSY : S_IDLE;
        end else if (hs) begin
          addr_d = next_addr;
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      master_d = MASTER;
      id_d     = ID;
      addr_d   = ADDR;
      cnt_d    = req_cnt;
      e_d      = req_e;
      kmask_d  = req_kmask;
      burst_d  = BURST;
      fbase_d  = req_fbase;
      wmask_d  = req_wmask;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= S_IDLE;
      master_q <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      e_q      <= '0;
      kmask_q  <= '0;
      burst_q  <= '0;
      fbase_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      master_q <= master_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      e_q      <= e_d;
      kmask_q  <= kmask_d;
      burst_q  <= burst_d;
      fbase_q  <= fbase_d;
      wmask_q  <= wmask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    O_VALID  = busy;
    O_LAST   = last;
    O_ADDR   = addr_q;
    O_MASTER = master_q;
    O_ID     = id_q;
  end

  logic unused_attr;
  assign unused_attr = ^{LOCK, CACHE, PROT};

endmodule

// File: tb/tb_axi_addr_latch.sv
// -----------------------------------------------------------------------------
// tb_axi_addr_latch
//
// Drives axi_addr_latch (p_size=3) with directed and random requests and
// compares every cycle against a queue of expected accesses computed from the
// burst rules in closed form. A second instance with p_size=2 covers the
// narrow-peripheral split case.
// -----------------------------------------------------------------------------
module tb_axi_addr_latch;

  localparam int W = 22;
  typedef logic [W-1:0] aq_t[$];
  typedef bit lq_t[$];

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [3:0]   MASTER = '0;
  logic [1:0]   ID = '0;
  logic [W-1:0] ADDR = '0;
  logic [3:0]   LEN = '0;
  logic [2:0]   SIZE = '0;
  logic [1:0]   BURST = '0;
  logic [1:0]   LOCK = '0;
  logic [3:0]   CACHE = '0;
  logic [2:0]   PROT = '0;
  logic         VALID = 1'b0;
  logic         valid2 = 1'b0;
  logic         READY, READY2;
  logic [3:0]   O_MASTER, O_MASTER2;
  logic [1:0]   O_ID, O_ID2;
  logic [W-1:0] O_ADDR, O_ADDR2;
  logic         O_LAST, O_LAST2, O_VALID, O_VALID2;

  logic rnd_ready = 1'b0;
  logic oready_rnd = 1'b0;
  logic oready_man = 1'b0;
  logic oready;
  assign oready = rnd_ready ? oready_rnd : oready_man;

  always #5 ACLK = ~ACLK;

  axi_addr_latch #(.masters(4), .width(W), .p_size(3), .id_bits(2)) u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .MASTER(MASTER), .ID(ID), .ADDR(ADDR),
    .LEN(LEN), .SIZE(SIZE), .BURST(BURST), .LOCK(LOCK), .CACHE(CACHE),
    .PROT(PROT), .VALID(VALID), .READY(READY), .O_MASTER(O_MASTER),
    .O_ID(O_ID), .O_ADDR(O_ADDR), .O_LAST(O_LAST), .O_VALID(O_VALID),
    .O_READY(oready)
  );

  axi_addr_latch #(.masters(4), .width(W), .p_size(2), .id_bits(2)) u_dut2 (
    .ACLK(ACLK), .ARESETn(ARESETn), .MASTER(MASTER), .ID(ID), .ADDR(ADDR),
    .LEN(LEN), .SIZE(SIZE), .BURST(BURST), .LOCK(LOCK), .CACHE(CACHE),
    .PROT(PROT), .VALID(valid2), .READY(READY2), .O_MASTER(O_MASTER2),
    .O_ID(O_ID2), .O_ADDR(O_ADDR2), .O_LAST(O_LAST2), .O_VALID(O_VALID2),
    .O_READY(oready)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Full access list of one request, straight from the burst rules.
  function automatic aq_t build(input logic [W-1:0] a, input int unsigned len,
                                input int unsigned size, input int unsigned burst,
                                input int unsigned p);
    aq_t r;
    int unsigned e, k, n, j, s;
    logic [W-1:0] step, ae, sa, bm, base;
    e    = (size < p) ? size : p;
    k    = 1 << (size - e);
    n    = (len + 1) * k;
    step = W'(1 << e);
    ae   = a & ~(step - W'(1));
    sa   = a & ~(W'((1 << size) - 1));
    bm   = W'(((len + 1) << size) - 1);
    for (int unsigned i = 0; i < n; i++) begin
      if (i == 0) r.push_back(a);
      else if (burst == 0) begin
        j    = i / k;
        s    = i % k;
        base = (j == 0) ? a : sa;
        r.push_back((s == 0) ? base : W'((base & ~(step - W'(1))) + W'(s) * step));
      end else if (burst == 2) begin
        r.push_back((a & ~bm) | (W'(ae + W'(i) * step) & bm));
      end else begin
        r.push_back(W'(ae + W'(i) * step));
      end
    end
    return r;
  endfunction

  // Reference model: pending accesses of the main instance.
  aq_t        q;
  logic [3:0] exp_master = '0;
  logic [1:0] exp_id = '0;
  bit         in_rst = 1'b0;
  bit         started = 1'b0;

  always @(posedge ACLK) begin
    bit busy_m, hs_m, last_m, ready_m;
    aq_t nl;
    if (!ARESETn) begin
      q.delete();
      in_rst  = 1'b1;
      started = 1'b1;
    end else begin
      in_rst  = 1'b0;
      busy_m  = (q.size() != 0);
      hs_m    = busy_m && oready;
      last_m  = hs_m && (q.size() == 1);
      ready_m = !busy_m || last_m;
      if (hs_m) void'(q.pop_front());
      if (started && VALID && ready_m) begin
        nl = build(ADDR, LEN, SIZE, BURST, 3);
        foreach (nl[i]) q.push_back(nl[i]);
        exp_master = MASTER;
        exp_id     = ID;
      end
    end
  end

  // Capture of observed accesses for the directed literal checks.
  bit   cap_en = 1'b0;
  aq_t  cap, cap2;
  lq_t  capl, capl2;

  always @(negedge ACLK) begin
    if (in_rst) begin
      chk("rst_valid", {31'd0, O_VALID}, 32'd0);
      chk("rst_last", {31'd0, O_LAST}, 32'd0);
      chk("rst_addr", 32'(O_ADDR), 32'd0);
      chk("rst_master", 32'(O_MASTER), 32'd0);
      chk("rst_id", 32'(O_ID), 32'd0);
      chk("rst_ready", {31'd0, READY}, {31'd0, ARESETn});
    end else if (started) begin
      chk("valid", {31'd0, O_VALID}, {31'd0, q.size() != 0});
      chk("ready", {31'd0, READY},
          {31'd0, ARESETn && (q.size() == 0 || (q.size() == 1 && oready))});
      if (q.size() != 0) begin
        chk("addr", 32'(O_ADDR), 32'(q[0]));
        chk("last", {31'd0, O_LAST}, {31'd0, q.size() == 1});
        chk("master", 32'(O_MASTER), 32'(exp_master));
        chk("id", 32'(O_ID), 32'(exp_id));
      end else begin
        chk("last_idle", {31'd0, O_LAST}, 32'd0);
      end
    end
    if (cap_en && O_VALID && oready) begin
      cap.push_back(O_ADDR);
      capl.push_back(O_LAST);
    end
    if (cap_en && O_VALID2 && oready) begin
      cap2.push_back(O_ADDR2);
      capl2.push_back(O_LAST2);
    end
  end

  always begin
    @(posedge ACLK);
    #1;
    oready_rnd = ($urandom_range(0, 9) < 7);
  end

  task automatic send(input logic [3:0] m, input logic [1:0] id, input logic [W-1:0] a,
                      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit acc;
    MASTER = m; ID = id; ADDR = a; LEN = len; SIZE = size; BURST = burst;
    LOCK  = 2'($urandom); CACHE = 4'($urandom); PROT = 3'($urandom);
    VALID = 1'b1;
    acc   = 1'b0;
    for (int i = 0; i < 4000 && !acc; i++) begin
      @(negedge ACLK);
      acc = READY;
      @(posedge ACLK);
      #1;
    end
    chk("send_accept", {31'd0, acc}, 32'd1);
    VALID = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge ACLK);
      if (!O_VALID) done = 1'b1;
    end
    chk(nm, {31'd0, done}, 32'd1);
    chk({nm, "_ready"}, {31'd0, READY}, 32'd1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic cmp_list(input string nm, input aq_t exp, input aq_t got, input lq_t gl);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk({nm, "_addr"}, 32'(got[i]), 32'(exp[i]));
      chk({nm, "_last"}, {31'd0, gl[i]}, {31'd0, i == exp.size() - 1});
    end
  endtask

  task automatic pin_model(input string nm, input aq_t m, input aq_t exp);
    chk({nm, "_count"}, m.size(), exp.size());
    for (int i = 0; i < exp.size() && i < m.size(); i++)
      chk({nm, "_addr"}, 32'(m[i]), 32'(exp[i]));
  endtask

  initial begin
    aq_t e;
    bit  done;
    logic [3:0] len;
    logic [1:0] burst;

    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    cap_en = 1'b1;
    oready_man = 1'b1;

    // 1: INCR, four 8-byte beats
    e = '{22'h100, 22'h108, 22'h110, 22'h118};
    pin_model("m1", build(22'h100, 3, 3, 1, 3), e);
    cap.delete(); capl.delete();
    send(4'b0001, 2'd1, 22'h100, 4'd3, 3'd3, 2'd1);
    wait_idle("t1_idle");
    cmp_list("t1", e, cap, capl);

    // 2: 8-byte beats on a 4-byte peripheral
    e = '{22'h40, 22'h44, 22'h48, 22'h4C};
    pin_model("m2", build(22'h40, 1, 3, 1, 2), e);
    cap2.delete(); capl2.delete();
    MASTER = 4'b0010; ID = 2'd2; ADDR = 22'h40; LEN = 4'd1; SIZE = 3'd3; BURST = 2'd1;
    valid2 = 1'b1;
    @(negedge ACLK);
    chk("t2_ready", {31'd0, READY2}, 32'd1);
    @(posedge ACLK);
    #1 valid2 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge ACLK);
      if (!O_VALID2) done = 1'b1;
    end
    chk("t2_idle", {31'd0, done}, 32'd1);
    cmp_list("t2", e, cap2, capl2);
    @(posedge ACLK);
    #1;

    // 3: WRAP on a 32-byte boundary
    e = '{22'h38, 22'h20, 22'h28, 22'h30};
    pin_model("m3", build(22'h38, 3, 3, 2, 3), e);
    cap.delete(); capl.delete();
    send(4'b0100, 2'd3, 22'h38, 4'd3, 3'd3, 2'd2);
    wait_idle("t3_idle");
    cmp_list("t3", e, cap, capl);

    // 4: FIXED, address repeats
    e = '{22'h80, 22'h80, 22'h80};
    pin_model("m4", build(22'h80, 2, 2, 0, 3), e);
    cap.delete(); capl.delete();
    send(4'b1000, 2'd0, 22'h80, 4'd2, 3'd2, 2'd0);
    wait_idle("t4_idle");
    cmp_list("t4", e, cap, capl);

    // 5: consumer stall mid-burst, then back-to-back request
    send(4'b0001, 2'd1, 22'h200, 4'd3, 3'd3, 2'd1);
    fork
      send(4'b0010, 2'd2, 22'h300, 4'd1, 3'd3, 2'd1);
      begin
        @(negedge ACLK);
        chk("t5_first", 32'(O_ADDR), 32'h200);
        @(posedge ACLK);
        #1 oready_man = 1'b0;
        repeat (3) begin
          @(negedge ACLK);
          chk("t5_hold_addr", 32'(O_ADDR), 32'h208);
          chk("t5_hold_valid", {31'd0, O_VALID}, 32'd1);
          chk("t5_hold_last", {31'd0, O_LAST}, 32'd0);
          @(posedge ACLK);
          #1;
        end
        oready_man = 1'b1;
      end
    join
    @(negedge ACLK);
    chk("t5_b2b_valid", {31'd0, O_VALID}, 32'd1);
    chk("t5_b2b_addr", 32'(O_ADDR), 32'h300);
    chk("t5_b2b_master", 32'(O_MASTER), 32'h2);
    @(posedge ACLK);
    #1;
    wait_idle("t5_idle");

    // 6: reset in the middle of a burst
    send(4'b0100, 2'd1, 22'h400, 4'd15, 3'd3, 2'd1);
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("t6_valid", {31'd0, O_VALID}, 32'd0);
    chk("t6_addr", 32'(O_ADDR), 32'd0);
    chk("t6_ready", {31'd0, READY}, 32'd0);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("t6_ready_after", {31'd0, READY}, 32'd1);
    @(posedge ACLK);
    #1;

    // Random traffic with random consumer back-pressure
    cap_en = 1'b0;
    rnd_ready = 1'b1;
    for (int n = 0; n < 120; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge ACLK);
        #1;
      end
      burst = 2'($urandom_range(0, 3));
      len   = (burst == 2'd2) ? 4'((1 << $urandom_range(1, 4)) - 1) : 4'($urandom_range(0, 15));
      send(4'(1 << $urandom_range(0, 3)), 2'($urandom), W'($urandom), len,
           3'($urandom_range(0, 5)), burst);
    end
    wait_idle("rnd_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
